// File: rtl/nrisc_pc_stack.sv
// nrisc_pc_stack: program counter with a register-array return-address stack for CALL/RET/RETI
module nrisc_pc_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_en,
  input  logic [1:0]                 pc_ctrl,
  input  logic [ADDR_W-1:0]          jump_addr,
  input  logic [1:0]                 stack_ctrl,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [ADDR_W-1:0]          stack_top,
  output logic [$clog2(DEPTH+1)-1:0] stack_count,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_overflow,
  output logic                       stack_underflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc_inc, pc_nxt;
  logic [CW-1:0] cnt_m1, cnt_nxt;
  logic push_ok, pop_ok, ovf_nxt, unf_nxt;
  always_comb begin
    pc_inc = pc_out + ADDR_W'(1);
    cnt_m1 = stack_count - CW'(1);
    stack_empty = stack_count == '0;
    stack_full = stack_count == CW'(DEPTH);
    stack_top = stack_empty ? '0 : mem[cnt_m1[IW-1:0]];
    push_ok = stack_ctrl == 2'd1 && !stack_full;
    pop_ok = stack_ctrl == 2'd2 && !stack_empty;
    pc_nxt = pc_ctrl == 2'd0 ? pc_inc :
             pc_ctrl == 2'd2 ? jump_addr :
             (pc_ctrl == 2'd3 && !stack_empty) ? stack_top : pc_out;
    cnt_nxt = stack_ctrl == 2'd3 ? '0 :
              push_ok ? stack_count + CW'(1) :
              pop_ok ? cnt_m1 : stack_count;
    // flush wins over any flag raised by the same command
    ovf_nxt = stack_ctrl != 2'd3 && (stack_overflow || (stack_ctrl == 2'd1 && stack_full));
    unf_nxt = stack_ctrl != 2'd3 && (stack_underflow ||
              (stack_empty && (stack_ctrl == 2'd2 || pc_ctrl == 2'd3)));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out <= RESET_VECTOR;
      stack_count <= '0;
      stack_overflow <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (pc_en) begin
      pc_out <= pc_nxt;
      stack_count <= cnt_nxt;
      stack_overflow <= ovf_nxt;
      stack_underflow <= unf_nxt;
    end
  end
  always_ff @(posedge clk)
    if (rst && pc_en && push_ok) mem[stack_count[IW-1:0]] <= pc_inc;
endmodule

// File: tb/tb_nrisc_pc_stack.sv
// tb_nrisc_pc_stack: directed vectors with a scoreboard queue checked by an independent monitor
module tb_nrisc_pc_stack;
  logic clk = 0, rst = 0, pc_en = 0;
  logic [1:0] pc_ctrl = 0, stack_ctrl = 0;
  logic [15:0] jump_addr = 0, pc_out, stack_top;
  logic [3:0] stack_count;
  logic stack_full, stack_empty, stack_overflow, stack_underflow;
  typedef struct {
    int id;
    logic [15:0] pc, top;
    logic [3:0] cnt;
    logic ovf, unf;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0, id = 0;
  logic [15:0] ret [8];

  nrisc_pc_stack dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_ctrl(pc_ctrl), .jump_addr(jump_addr),
    .stack_ctrl(stack_ctrl), .pc_out(pc_out), .stack_top(stack_top),
    .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (pc_out !== e.pc || stack_top !== e.top || stack_count !== e.cnt ||
          stack_full !== (e.cnt == 4'd8) || stack_empty !== (e.cnt == 4'd0) ||
          stack_overflow !== e.ovf || stack_underflow !== e.unf) begin
        n_fail++;
        $display("FAIL step%0d: got pc=%h top=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h top=%h cnt=%0d ovf=%b unf=%b",
                 e.id, pc_out, stack_top, stack_count, stack_full, stack_empty,
                 stack_overflow, stack_underflow, e.pc, e.top, e.cnt, e.ovf, e.unf);
      end
    end
  end

  task automatic expect_st(input logic [15:0] pc, input logic [15:0] top,
                           input logic [3:0] cnt, input logic ovf, input logic unf);
    exp_t e;
    e.id = id++; e.pc = pc; e.top = top; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
    q.push_back(e);
  endtask

  task automatic step(input logic en, input logic [1:0] pcc, input logic [15:0] ja,
                      input logic [1:0] sc, input logic [15:0] pc, input logic [15:0] top,
                      input logic [3:0] cnt, input logic ovf, input logic unf);
    pc_en = en; pc_ctrl = pcc; jump_addr = ja; stack_ctrl = sc;
    @(posedge clk);
    #1 expect_st(pc, top, cnt, ovf, unf);
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 0;
    #1 expect_st(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1;
  endtask

  initial begin
    #1 expect_st(16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1;
    step(1, 0, 0, 0, 16'h0001, 0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0002, 0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0003, 0, 0, 0, 0);
    async_reset();
    // CALL / RET
    step(1, 2, 16'h0010, 0, 16'h0010, 0, 0, 0, 0);
    step(1, 2, 16'h0200, 1, 16'h0200, 16'h0011, 1, 0, 0);
    step(1, 3, 0, 2, 16'h0011, 0, 0, 0, 0);
    // nested calls to full, then overflow, then LIFO unwind
    step(1, 2, 16'h0005, 0, 16'h0005, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      ret[k] = (k == 0) ? 16'h0006 : 16'((k << 8) + 1);
      step(1, 2, 16'((k + 1) << 8), 1, 16'((k + 1) << 8), ret[k], 4'(k + 1), 0, 0);
    end
    step(1, 2, 16'h0900, 1, 16'h0900, 16'h0701, 8, 1, 0);
    for (int k = 7; k >= 0; k--)
      step(1, 3, 0, 2, ret[k], (k > 0) ? ret[k-1] : 16'h0000, 4'(k), 1, 0);
    // underflow on empty RET, then flush clears both flags
    step(1, 3, 0, 2, 16'h0006, 0, 0, 1, 1);
    step(1, 1, 0, 3, 16'h0006, 0, 0, 0, 0);
    // wraparound
    step(1, 2, 16'hFFFF, 0, 16'hFFFF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    step(1, 2, 16'hFFFF, 0, 16'hFFFF, 0, 0, 0, 0);
    step(1, 1, 0, 1, 16'hFFFF, 16'h0000, 1, 0, 0);
    // pc from top while pushing old pc+1
    step(1, 2, 16'h0040, 0, 16'h0040, 16'h0000, 1, 0, 0);
    step(1, 3, 0, 1, 16'h0000, 16'h0041, 2, 0, 0);
    // pc_en low freezes everything
    for (int k = 0; k < 4; k++)
      step(0, 2, 16'h1234, 1, 16'h0000, 16'h0041, 2, 0, 0);
    // reset during a pending push
    pc_en = 1; pc_ctrl = 2; jump_addr = 16'h1234; stack_ctrl = 1;
    async_reset();
    step(1, 0, 0, 0, 16'h0001, 0, 0, 0, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nrisc_pc_stack.md
Name: nrisc_pc_stack

Overview:
Program-counter and hardware return-address stack. It sits directly downstream of the NRISC control unit and consumes its PC-control, PC-enable and stack-control outputs. It drives the instruction-memory address, taking jump targets from the ULA output. CALL/RET/RETI are resolved here: return addresses are pushed and popped without touching data memory.

Parameters:
ADDR_W, 16, width of PC, jump target and stack entries
DEPTH, 8, number of return-address entries (power of two, >=2)
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  main clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
pc_en  input  1  PC/stack update enable from control unit (PC clock strobe); sampled on clk rising edge
pc_ctrl  input  2  PC source: 0 = PC+1, 1 = hold, 2 = jump_addr, 3 = stack top
jump_addr  input  ADDR_W  jump/call target from ULA output
stack_ctrl  input  2  0 = none, 1 = push, 2 = pop, 3 = flush
pc_out  output  ADDR_W  current PC, instruction-memory address
stack_top  output  ADDR_W  entry at top of stack; 0 when empty
stack_count  output  $clog2(DEPTH+1)  number of valid entries
stack_full  output  1  stack_count == DEPTH
stack_empty  output  1  stack_count == 0
stack_overflow  output  1  sticky: push attempted while full
stack_underflow  output  1  sticky: pop or pc_ctrl=3 attempted while empty

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - pc_out = RESET_VECTOR.
  - stack_count = 0, stack_top = 0, stack_empty = 1, stack_full = 0.
  - Both sticky flags = 0.
  - Stack RAM contents are not cleared (don't care).
  - Reset mid-operation aborts any push or pop; the first active edge after rst rises sees the reset state.
- All updates occur on a clk rising edge with pc_en=1. With pc_en=0, all state holds regardless of pc_ctrl/stack_ctrl.
- Every edge computation uses pre-edge values of pc_out, stack_top and stack_count.
- PC update:
  - 0: pc_out+1, modulo 2^ADDR_W (all-ones wraps to 0).
  - 1: hold.
  - 2: jump_addr.
  - 3 with stack non-empty: stack_top.
  - 3 with stack empty: hold pc_out and set stack_underflow.
- Push (stack_ctrl=1):
  - Writes (pre-edge pc_out + 1) mod 2^ADDR_W to slot stack_count, then stack_count+1.
  - If full: no write, count unchanged, stack_overflow set.
- Pop (stack_ctrl=2):
  - stack_count-1.
  - If empty: count unchanged, stack_underflow set.
- Flush (stack_ctrl=3): stack_count = 0 and both sticky flags cleared. This takes priority over any flag set in the same cycle.
- Canonical sequences:
  - CALL = pc_ctrl 2 + push: pushes return address, PC = target.
  - RET/RETI = pc_ctrl 3 + pop: PC = old top, entry removed.
- Simultaneous pc_ctrl=3 + push: PC = old top, then push of old PC+1 proceeds (full check on pre-edge count).
- stack_top, stack_full, stack_empty and stack_count are combinational from registered state and valid in the same cycle as the state change. No read latency is allowed: the stack is a register array, not synchronous RAM.
- Sticky flags clear only on reset or flush.
- Latency: one edge from pc_en-qualified command to updated pc_out/stack outputs.

Test Plan:
1. Reset then 3 edges with pc_en=1, pc_ctrl=0 -> pc_out 0000,0001,0002,0003. Assert rst=0 between edges -> pc_out 0000 immediately.
2. PC=0x0010, CALL (pc_ctrl=2, jump_addr=0x0200, push) -> pc_out=0x0200, stack_top=0x0011, count=1. RET (pc_ctrl=3, pop) -> pc_out=0x0011, count=0, empty=1.
3. Nested CALLs from PCs 0x0005,0x0100,...: perform DEPTH=8 pushes -> full=1. Ninth push -> count stays 8, overflow=1, top unchanged. Then 8 RETs return addresses in LIFO order.
4. Empty stack, pc_ctrl=3 + pop -> pc_out held, count 0, underflow=1. Then flush -> underflow=0, overflow=0.
5. pc_out=0xFFFF, pc_ctrl=0 -> 0x0000. pc_out=0xFFFF, push -> stack_top=0x0000.
6. pc_en=0 with pc_ctrl=2, stack_ctrl=1 for 4 edges -> no change to any output. Asserting rst=0 mid-sequence during a push cycle -> count 0, pc_out=RESET_VECTOR.
